// File: rtl/mac_fifo_pkg.sv
// Shared types and helpers for the store-and-forward MAC packet FIFO.
package mac_fifo_pkg;

  localparam int STATUS_W   = 4;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    DROP   = 2'd3
  } wr_state_e;

  // Widest beat layout; the FIFO packs {data, keep, last, user} in this order.
  typedef struct packed {
    logic [MAX_DATA_W-1:0]   data;
    logic [MAX_DATA_W/8-1:0] keep;
    logic                    last;
    logic                    user;
  } beat_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int beat_w(input int data_w);
    return data_w + data_w / 8 + 2;
  endfunction

endpackage

// File: rtl/mac_fifo_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
module mac_fifo_ram
  import mac_fifo_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_re,
  input  logic [clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]        o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mac_pkt_fifo.sv
// Store-and-forward packet FIFO: frames become visible to the reader only
// once their good tlast is written; bad or overflowed frames are rolled back.
//
//   state  | meaning
//   RESYNC | after reset, discard beats up to and including the next tlast
//   IDLE   | between frames, next valid beat starts a frame
//   ACTIVE | storing a frame speculatively at wr_addr
//   DROP   | frame overflowed, discard beats up to its tlast
module mac_pkt_fifo
  import mac_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4096,
  parameter bit DROP_BAD   = 1'b1
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    fifo_overflow,
  output logic                    fifo_bad_frame,
  output logic [STATUS_W-1:0]     fifo_status,
  output logic [clog2(DEPTH):0]   frame_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = beat_w(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic                  user;
  } fifo_beat_t;

  wr_state_e     r_wr_state, w_wr_state_nxt;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_frame_count;
  logic [PW-1:0] w_occ;
  logic [4:0]    w_scaled;
  logic [STATUS_W-1:0] r_status;
  logic          w_full;
  logic          w_we, w_commit, w_ovf, w_bad;
  logic          r_ovf, r_bad;
  fifo_beat_t    w_wr_beat;

  logic          w_fetch, r_pend, w_pop, w_pop_last;
  logic [1:0]    r_out_cnt, w_used;
  logic          r_head;
  fifo_beat_t    r_skid [2];
  fifo_beat_t    w_out;
  logic [BW-1:0] w_ram_rdata;

  assign w_full = ((r_wr_addr - r_rd_ptr) == PW'(DEPTH));

  assign w_wr_beat.data = s_axis_tdata;
  assign w_wr_beat.keep = s_axis_tkeep;
  assign w_wr_beat.last = s_axis_tlast;
  assign w_wr_beat.user = !DROP_BAD && s_axis_tuser && s_axis_tlast;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wr_state <= RESYNC;
      r_wr_ptr   <= '0;
      r_wr_addr  <= '0;
      r_ovf      <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_ovf      <= w_ovf;
      r_bad      <= w_bad;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wr_addr_nxt  = r_wr_addr;
    w_we           = 1'b0;
    w_commit       = 1'b0;
    w_ovf          = 1'b0;
    w_bad          = 1'b0;
    case (r_wr_state)
      RESYNC: begin
        if (s_axis_tvalid && s_axis_tlast) w_wr_state_nxt = IDLE;
      end
      IDLE, ACTIVE: begin
        if (s_axis_tvalid) begin
          if (w_full) begin
            w_ovf          = 1'b1;
            w_wr_addr_nxt  = r_wr_ptr;
            w_wr_state_nxt = s_axis_tlast ? IDLE : DROP;
          end else if (s_axis_tlast && s_axis_tuser && DROP_BAD) begin
            w_bad          = 1'b1;
            w_wr_addr_nxt  = r_wr_ptr;
            w_wr_state_nxt = IDLE;
          end else begin
            w_we          = 1'b1;
            w_wr_addr_nxt = r_wr_addr + PW'(1);
            if (s_axis_tlast) begin
              w_commit       = 1'b1;
              w_wr_ptr_nxt   = r_wr_addr + PW'(1);
              w_wr_state_nxt = IDLE;
            end else begin
              w_wr_state_nxt = ACTIVE;
            end
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) w_wr_state_nxt = IDLE;
      end
      default: w_wr_state_nxt = RESYNC;
    endcase
  end

  mac_fifo_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr[AW-1:0]),
    .i_wdata (w_wr_beat),
    .i_re    (w_fetch),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Prefetch committed beats whenever the skid plus the read in flight has room.
  assign w_out      = r_skid[r_head];
  assign w_pop      = (r_out_cnt != 2'd0) && m_axis_tready;
  assign w_pop_last = w_pop && w_out.last;
  assign w_used     = r_out_cnt + {1'b0, r_pend};
  assign w_fetch    = (r_wr_ptr != r_rd_ptr) &&
                      ((w_used < 2'd2) || ((w_used == 2'd2) && w_pop));

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_pend    <= 1'b0;
      r_out_cnt <= 2'd0;
      r_head    <= 1'b0;
    end else begin
      r_pend <= w_fetch;
      if (w_fetch) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (r_pend) r_skid[r_head ^ r_out_cnt[0]] <= fifo_beat_t'(w_ram_rdata);
      r_out_cnt <= r_out_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      if (w_pop) r_head <= ~r_head;
    end
  end

  assign w_occ    = r_wr_ptr - r_rd_ptr;
  assign w_scaled = w_occ[PW-1 -: 5];

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_frame_count <= '0;
      r_status      <= '0;
    end else begin
      if (w_commit && !w_pop_last) r_frame_count <= r_frame_count + PW'(1);
      else if (!w_commit && w_pop_last) r_frame_count <= r_frame_count - PW'(1);
      r_status <= w_scaled[4] ? 4'd15 : w_scaled[3:0];
    end
  end

  assign m_axis_tvalid  = (r_out_cnt != 2'd0);
  assign m_axis_tdata   = w_out.data;
  assign m_axis_tkeep   = w_out.keep;
  assign m_axis_tlast   = m_axis_tvalid && w_out.last;
  assign m_axis_tuser   = m_axis_tvalid && w_out.user;
  assign fifo_overflow  = r_ovf;
  assign fifo_bad_frame = r_bad;
  assign fifo_status    = r_status;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_mac_pkt_fifo.sv
// Directed bench for mac_pkt_fifo at DATA_WIDTH=32, DEPTH=16, DROP_BAD=1.
module tb_mac_pkt_fifo;

  logic        aclk;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic        fifo_overflow;
  logic        fifo_bad_frame;
  logic [3:0]  fifo_status;
  logic [4:0]  frame_count;

  mac_pkt_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .DROP_BAD   (1'b1)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .fifo_overflow  (fifo_overflow),
    .fifo_bad_frame (fifo_bad_frame),
    .fifo_status    (fifo_status),
    .frame_count    (frame_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tl_cyc = 0;
  int rise_cyc = -100;
  int ovf_cnt = 0;
  int bad_cnt = 0;
  int gap_len = 0;
  int max_gap = 0;
  bit gap_chk = 0;
  bit after_last = 0;
  bit pat_en = 0;
  int pat_idx = 0;
  logic [0:3] rdy_pat = 4'b1011;
  logic        p_valid = 0;
  logic        p_ready = 0;
  logic [37:0] p_beat = '0;
  logic [37:0] rx_q [$];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int f, input int b);
    return {f[7:0], 8'h5A, b[15:0]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
    if (pat_en) begin
      m_axis_tready = rdy_pat[pat_idx];
      pat_idx = (pat_idx + 1) % 4;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input logic [3:0] lk, input logic u);
    for (int b = 0; b < n; b++)
      beat(dat(f, b), (b == n - 1) ? lk : 4'hF, b == n - 1, (b == n - 1) ? u : 1'b0);
    tl_cyc = cyc;
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int i = 0; i < 300 && rx_q.size() < n; i++) tick();
    repeat (4) tick();
    check({tag, "_beats"}, rx_q.size(), n);
  endtask

  task automatic check_beats(input string tag, input int f, input int n, input logic [3:0] lk);
    logic [37:0] got, exp;
    for (int b = 0; b < n; b++) begin
      exp = {dat(f, b), (b == n - 1) ? lk : 4'hF, b == n - 1, 1'b0};
      got = (rx_q.size() > 0) ? rx_q.pop_front() : '1;
      check(tag, got, exp);
    end
  endtask

  // Output monitor: collects handshakes, checks hold during stalls, counts pulses.
  always @(negedge aclk) begin
    if (reset) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready)
        check("hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
              {1'b1, p_beat});
      if (m_axis_tvalid && !p_valid) rise_cyc = cyc;
      if (fifo_overflow) ovf_cnt++;
      if (fifo_bad_frame) bad_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (gap_chk && after_last && gap_len > max_gap) max_gap = gap_len;
        gap_len = 0;
        after_last = m_axis_tlast;
        rx_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
      end else if (!m_axis_tvalid) begin
        gap_len++;
      end
      p_valid = m_axis_tvalid;
      p_ready = m_axis_tready;
      p_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    int b0, o0, ovf_beat, lat;
    reset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;

    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_ovf", fifo_overflow, 0);
    check("rst_bad", fifo_bad_frame, 0);
    check("rst_status", fifo_status, 0);
    check("rst_fc", frame_count, 0);
    reset = 1'b0;

    // Tail of a frame already in flight at release must be discarded.
    beat(32'hDEAD_0001, 4'hF, 1'b0, 1'b0);
    beat(32'hDEAD_0002, 4'hF, 1'b1, 1'b0);
    repeat (6) tick();
    check("resync_fc", frame_count, 0);
    check("resync_q", rx_q.size(), 0);

    // 64-byte frame, streaming out with tready held high.
    rise_cyc = -100;
    send_frame(1, 16, 4'hF, 1'b0);
    check("t1_fc1", frame_count, 1);
    tick();
    check("t1_status_full", fifo_status, 15);
    wait_rx("t1", 16);
    check_beats("t1_beat", 1, 16, 4'hF);
    lat = rise_cyc - tl_cyc;
    check("t1_latency_2to3", (lat >= 2) && (lat <= 3), 1);
    check("t1_fc0", frame_count, 0);
    check("t1_status0", fifo_status, 0);

    // 61-byte bad frame is discarded, a good one after it survives.
    b0 = bad_cnt;
    send_frame(2, 16, 4'h1, 1'b1);
    repeat (4) tick();
    check("t2_bad_pulses", bad_cnt - b0, 1);
    check("t2_tvalid", m_axis_tvalid, 0);
    check("t2_fc", frame_count, 0);
    check("t2_status", fifo_status, 0);
    send_frame(3, 5, 4'h3, 1'b0);
    wait_rx("t2", 5);
    check_beats("t2_beat", 3, 5, 4'h3);

    // Overflow: 20 beats into 16 slots with the reader stalled.
    m_axis_tready = 1'b0;
    o0 = ovf_cnt;
    ovf_beat = 0;
    for (int b = 0; b < 20; b++) begin
      beat(dat(30, b), 4'hF, b == 19, 1'b0);
      if (fifo_overflow && ovf_beat == 0) ovf_beat = b + 1;
    end
    repeat (3) tick();
    check("t3_ovf_beat", ovf_beat, 17);
    check("t3_ovf_pulses", ovf_cnt - o0, 1);
    check("t3_fc", frame_count, 0);
    check("t3_tvalid", m_axis_tvalid, 0);
    check("t3_status", fifo_status, 0);
    send_frame(31, 8, 4'h7, 1'b0);
    repeat (4) tick();
    check("t3_fc1", frame_count, 1);
    check("t3_tvalid_stalled", m_axis_tvalid, 1);
    check("t3_status_6", fifo_status, 6);
    m_axis_tready = 1'b1;
    wait_rx("t3", 8);
    check_beats("t3_beat", 31, 8, 4'h7);

    // Ten back-to-back 3-beat frames across the wrap, tready 1-0-1-1.
    gap_len = 0;
    max_gap = 0;
    after_last = 0;
    gap_chk = 1;
    pat_idx = 0;
    pat_en = 1;
    for (int f = 40; f < 50; f++) send_frame(f, 3, 4'hC, 1'b0);
    wait_rx("t4", 30);
    pat_en = 0;
    gap_chk = 0;
    m_axis_tready = 1'b1;
    for (int f = 40; f < 50; f++) check_beats("t4_beat", f, 3, 4'hC);
    check("t4_max_gap_le1", max_gap <= 1, 1);
    check("t4_fc", frame_count, 0);

    // Reset during a frame, released on beat 5 of 10.
    beat(dat(50, 0), 4'hF, 1'b0, 1'b0);
    beat(dat(50, 1), 4'hF, 1'b0, 1'b0);
    reset = 1'b1;
    beat(dat(50, 2), 4'hF, 1'b0, 1'b0);
    check("t5_rst_tvalid_a", m_axis_tvalid, 0);
    check("t5_rst_fc", frame_count, 0);
    beat(dat(50, 3), 4'hF, 1'b0, 1'b0);
    check("t5_rst_tvalid_b", m_axis_tvalid, 0);
    reset = 1'b0;
    for (int b = 4; b < 10; b++) beat(dat(50, b), 4'hF, b == 9, 1'b0);
    repeat (5) tick();
    check("t5_resync_fc", frame_count, 0);
    check("t5_resync_q", rx_q.size(), 0);
    check("t5_resync_tvalid", m_axis_tvalid, 0);
    rise_cyc = -100;
    send_frame(51, 4, 4'h3, 1'b0);
    check("t5_fc1", frame_count, 1);
    wait_rx("t5", 4);
    check_beats("t5_beat", 51, 4, 4'h3);
    lat = rise_cyc - tl_cyc;
    check("t5_latency_2to3", (lat >= 2) && (lat <= 3), 1);
    check("t5_fc0", frame_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
